bit_serial_pixel_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 15 +
 rtl/approx_fa_cell.sv | 28 ++
 rtl/bit_serial_pixel_adder.sv | 121 ++++++++++++
 tb/tb_bit_serial_pixel_adder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial pixel adders and their 1-bit cell.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int PIX_W_DEFAULT = 8;

  localparam bit APPROX_CELL = 1'b1;
  localparam bit EXACT_CELL  = 1'b0;

endpackage

// File: rtl/approx_fa_cell.sv
// 1-bit adder cell, combinational: approximate (s = ~maj) or exact full adder (s = a^b^c).
// Carry out is the majority function in both modes.
module approx_fa_cell
  import adder_pkg::*;
#(
  parameter bit APPROX = APPROX_CELL
) (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic maj;

  assign maj = (a & b) | (a & c) | (b & c);
  assign co  = maj;

  generate
    if (APPROX) begin : g_approx
      assign s = ~maj;
    end else begin : g_exact
      assign s = a ^ b ^ c;
    end
  endgenerate

endmodule

// File: rtl/bit_serial_pixel_adder.sv
// LSB-first serial pixel adder: PIX_W shift cycles per pair, result held in DONE until out_ready.
// in_ready only in IDLE; no accept while busy, so throughput is one pair per PIX_W+2 cycles.
module bit_serial_pixel_adder
  import adder_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEFAULT,
  parameter bit APPROX = APPROX_CELL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] pix_a,
  input  logic [PIX_W-1:0] pix_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W:0]   sum,
  output logic             busy
);

  localparam int CNT_W = $clog2(PIX_W);

  state_e             state_q, state_d;
  logic [PIX_W-1:0]   a_sr_q, a_sr_d;
  logic [PIX_W-1:0]   b_sr_q, b_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PIX_W-2:0]   acc_q, acc_d;
  logic [PIX_W:0]     sum_q, sum_d;
  logic               out_valid_q, out_valid_d;

  logic               cell_s;
  logic               cell_co;
  logic [PIX_W-1:0]   acc_shift;

  approx_fa_cell #(
    .APPROX (APPROX)
  ) u_cell (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .c  (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  // Result bits enter from the top; the last bit skips acc and goes straight into sum.
  assign acc_shift = {cell_s, acc_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = pix_a;
          b_sr_d  = pix_b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = acc_shift[PIX_W-1:1];
        carry_d = cell_co;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        if (cnt_q == CNT_W'(PIX_W - 1)) begin
          sum_d       = {cell_co, cell_s, acc_q};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_bit_serial_pixel_adder.sv
// Runs an approximate and an exact adder in lockstep on identical stimulus and checks both.
module tb_bit_serial_pixel_adder;

  localparam int PIX_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             out_ready;
  logic [PIX_W-1:0] pix_a;
  logic [PIX_W-1:0] pix_b;

  logic             in_ready_a, out_valid_a, busy_a;
  logic [PIX_W:0]   sum_a;
  logic             in_ready_e, out_valid_e, busy_e;
  logic [PIX_W:0]   sum_e;

  int n_pass;
  int n_total;

  bit_serial_pixel_adder #(.PIX_W(PIX_W), .APPROX(1'b1)) u_apx (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .pix_a     (pix_a),
    .pix_b     (pix_b),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .sum       (sum_a),
    .busy      (busy_a)
  );

  bit_serial_pixel_adder #(.PIX_W(PIX_W), .APPROX(1'b0)) u_ex (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_e),
    .pix_a     (pix_a),
    .pix_b     (pix_b),
    .out_valid (out_valid_e),
    .out_ready (out_ready),
    .sum       (sum_e),
    .busy      (busy_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PIX_W-1:0] a;
    logic [PIX_W-1:0] b;
    logic [PIX_W:0]   exp_apx;
    logic [PIX_W:0]   exp_ex;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // in_valid is raised just after edge T, the pair is taken at edge T+1,
  // and the result must appear after edge T+PIX_W+1 (not earlier).
  task automatic run_pair(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                          input logic [PIX_W:0] ea, input logic [PIX_W:0] ee, input string tag);
    @(posedge clk); #1;
    pix_a = a; pix_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " in_ready after accept"}, {15'd0, in_ready_a | in_ready_e}, 16'd0);
    check({tag, " busy after accept"}, {14'd0, busy_a, busy_e}, 16'h3);
    repeat (PIX_W - 1) @(posedge clk);
    @(negedge clk);
    check({tag, " out_valid not early"}, {14'd0, out_valid_a, out_valid_e}, 16'h0);
    @(posedge clk);
    @(negedge clk);
    check({tag, " out_valid on time"}, {14'd0, out_valid_a, out_valid_e}, 16'h3);
    check({tag, " sum approx"}, {7'd0, sum_a}, {7'd0, ea});
    check({tag, " sum exact"}, {7'd0, sum_e}, {7'd0, ee});
    @(negedge clk);
    check({tag, " out_valid drops"}, {14'd0, out_valid_a, out_valid_e}, 16'h0);
    check({tag, " back to idle"}, {12'd0, in_ready_a, in_ready_e, busy_a, busy_e}, 16'hC);
  endtask

  initial begin
    logic saw_valid;
    n_pass    = 0;
    n_total   = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    pix_a     = '0;
    pix_b     = '0;
    rst_n     = 1'b1;

    vecs[0] = '{a: 8'h00, b: 8'h00, exp_apx: 9'h0FF, exp_ex: 9'h000};
    vecs[1] = '{a: 8'hFF, b: 8'h01, exp_apx: 9'h100, exp_ex: 9'h100};
    vecs[2] = '{a: 8'h0F, b: 8'h00, exp_apx: 9'h0FF, exp_ex: 9'h00F};
    vecs[3] = '{a: 8'h55, b: 8'hAA, exp_apx: 9'h0FF, exp_ex: 9'h0FF};
    vecs[4] = '{a: 8'h80, b: 8'h80, exp_apx: 9'h17F, exp_ex: 9'h100};
    vecs[5] = '{a: 8'h3C, b: 8'h0F, exp_apx: 9'h0C3, exp_ex: 9'h04B};

    // Reset held for 3 cycles; in_ready must already be high during reset.
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_ready during reset", {14'd0, in_ready_a, in_ready_e}, 16'h3);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", {14'd0, in_ready_a, in_ready_e}, 16'h3);
    check("reset out_valid", {14'd0, out_valid_a, out_valid_e}, 16'h0);
    check("reset busy", {14'd0, busy_a, busy_e}, 16'h0);
    check("reset sum", {7'd0, sum_a | sum_e}, 16'h0);

    for (int i = 0; i < 6; i++) begin
      run_pair(vecs[i].a, vecs[i].b, vecs[i].exp_apx, vecs[i].exp_ex, $sformatf("vec%0d", i));
    end

    // Backpressure: stray in_valid during SHIFT, then a 5-cycle stall in DONE.
    out_ready = 1'b0;
    @(posedge clk); #1;
    pix_a = 8'h3C; pix_b = 8'h0F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    pix_a = 8'hFF; pix_b = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    check("bp in_ready in shift", {14'd0, in_ready_a, in_ready_e}, 16'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (PIX_W - 2) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp stall%0d out_valid", k), {14'd0, out_valid_a, out_valid_e}, 16'h3);
      check($sformatf("bp stall%0d sum approx", k), {7'd0, sum_a}, 16'h0C3);
      check($sformatf("bp stall%0d sum exact", k), {7'd0, sum_e}, 16'h04B);
      check($sformatf("bp stall%0d in_ready", k), {14'd0, in_ready_a, in_ready_e}, 16'h0);
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release out_valid", {14'd0, out_valid_a, out_valid_e}, 16'h0);
    check("bp release in_ready", {14'd0, in_ready_a, in_ready_e}, 16'h3);
    run_pair(8'h80, 8'h80, 9'h17F, 9'h100, "bp next");

    // Reset abort while bit 4 of FF+FF is in the cell.
    @(posedge clk); #1;
    pix_a = 8'hFF; pix_b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort in_ready", {14'd0, in_ready_a, in_ready_e}, 16'h3);
    check("abort busy", {14'd0, busy_a, busy_e}, 16'h0);
    check("abort out_valid", {14'd0, out_valid_a, out_valid_e}, 16'h0);
    check("abort sum", {7'd0, sum_a | sum_e}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid_a || out_valid_e) saw_valid = 1'b1;
    end
    check("abort no out_valid pulse", {15'd0, saw_valid}, 16'h0);
    run_pair(8'hFF, 8'hFF, 9'h100, 9'h1FE, "after abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
